prga_fifo_upsizer: RTL and testbench

PRGA_FIFO_UPSIZER -- requirements
Module: prga_fifo_upsizer

---
 rtl/prga_fifo_upsizer.sv | 89 ++++++++
 tb/tb_prga_fifo_upsizer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_fifo_upsizer.sv
`timescale 1ns/1ps
// prga_fifo_upsizer: packs MULTIPLIER upstream FIFO words into one wide word.
// Ports: clk, rst (async, high); upstream empty_i/rd_i/dout_i; downstream empty/rd/dout.
//
// The upstream side is a FIFO read port that is either lookahead
// (dout_i valid while empty_i is low) or registered (dout_i valid the
// cycle after rd_i). The downstream side is always lookahead: dout is
// valid while empty is low, and rd consumes it.
module prga_fifo_upsizer #(
  parameter int DATA_WIDTH      = 8,
  parameter int MULTIPLIER      = 4,
  parameter int INPUT_LOOKAHEAD = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             empty_i,
  output logic                             rd_i,
  input  logic [DATA_WIDTH-1:0]            dout_i,
  output logic                             empty,
  input  logic                             rd,
  output logic [DATA_WIDTH*MULTIPLIER-1:0] dout
);

  localparam int CW = $clog2(MULTIPLIER + 1);
  localparam int IW = $clog2(MULTIPLIER);

  localparam logic [CW-1:0] FULL   = CW'(MULTIPLIER);
  localparam logic [CW:0]   FULL_E = (CW + 1)'(MULTIPLIER);

  logic [DATA_WIDTH-1:0] slots [MULTIPLIER];
  logic [CW-1:0]         cnt;
  logic                  pending;
  logic                  pop;
  logic                  capture;
  logic [CW:0]           eff;
  logic [IW-1:0]         idx;

  assign empty = (cnt != FULL);
  assign pop   = rd & ~empty;

  // Words already held plus the one still in flight from the upstream FIFO.
  assign eff = {1'b0, cnt} + {{CW{1'b0}}, pending};

  // A pop this cycle frees every slot, so reading in the same cycle keeps
  // the stream gap-free across packed-word boundaries.
  assign rd_i = ~empty_i & ((eff < FULL_E) | pop);

  // cnt never reaches MULTIPLIER while a capture happens, so the low bits
  // are a valid slot index whenever they are used.
  assign idx = cnt[IW-1:0];

  for (genvar k = 0; k < MULTIPLIER; k++) begin : g_pack
    assign dout[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
  end

  if (INPUT_LOOKAHEAD != 0) begin : g_la
    assign pending = 1'b0;
    assign capture = rd_i;
  end else begin : g_nla
    // Data for a read arrives one cycle later; pending marks that cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pending <= 1'b0;
      end else begin
        pending <= rd_i;
      end
    end
    assign capture = pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= capture ? CW'(1) : '0;
    end else if (capture) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Slot storage carries no reset; contents are only observable once
  // cnt has been refilled after reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      slots[pop ? IW'(0) : idx] <= dout_i;
    end
  end

endmodule

// File: tb/tb_prga_fifo_upsizer.sv
`timescale 1ns/1ps
// Scoreboard bench for prga_fifo_upsizer: one lookahead and one
// registered-input instance, each fed by a small upstream FIFO model.
module tb_prga_fifo_upsizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vecs = 0;
  int bad  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Instance A: lookahead upstream
  logic        empty_i_a, rd_i_a, empty_a, rd_a;
  logic [7:0]  dout_i_a;
  logic [31:0] dout_a;

  // Instance B: registered upstream
  logic        empty_i_b, rd_i_b, empty_b, rd_b;
  logic [7:0]  dout_i_b;
  logic [31:0] dout_b;

  prga_fifo_upsizer #(
    .DATA_WIDTH(8), .MULTIPLIER(4), .INPUT_LOOKAHEAD(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .empty_i(empty_i_a), .rd_i(rd_i_a), .dout_i(dout_i_a),
    .empty(empty_a), .rd(rd_a), .dout(dout_a)
  );

  prga_fifo_upsizer #(
    .DATA_WIDTH(8), .MULTIPLIER(4), .INPUT_LOOKAHEAD(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .empty_i(empty_i_b), .rd_i(rd_i_b), .dout_i(dout_i_b),
    .empty(empty_b), .rd(rd_b), .dout(dout_b)
  );

  logic [7:0]  up_a [$];
  logic [7:0]  up_b [$];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  int          pop_t_a [$];

  logic       sparse = 1'b0;
  logic       phase  = 1'b0;
  logic [7:0] junk_a;
  logic [7:0] v_b;
  logic       got_b;

  // Upstream A: lookahead FIFO, optionally gated every other cycle.
  always @(posedge clk) begin
    if (!rst && rd_i_a && up_a.size() > 0) junk_a = up_a.pop_front();
    #1;
    phase     = ~phase;
    empty_i_a = (up_a.size() == 0) || (sparse && phase);
    dout_i_a  = (up_a.size() > 0) ? up_a[0] : 8'h00;
  end

  // Upstream B: data appears the cycle after the read.
  always @(posedge clk) begin
    got_b = 1'b0;
    if (!rst && rd_i_b && up_b.size() > 0) begin
      v_b   = up_b.pop_front();
      got_b = 1'b1;
    end
    #1;
    if (got_b) dout_i_b = v_b;
    empty_i_b = (up_b.size() == 0);
  end

  int  drops = 0;
  int  viol  = 0;
  logic watch = 1'b0;

  always @(negedge clk) begin
    if (!rst && rd_i_a && empty_i_a) viol++;
    if (!rst && rd_i_b && empty_i_b) viol++;
    if (watch && !empty_i_a && !rd_i_a) drops++;
  end

  // Monitors: compare every consumed word against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rd_a && !empty_a) begin
      pop_t_a.push_back(cyc);
      if (exp_a.size() == 0) begin
        vecs++;
        bad++;
        $display("FAIL word_a_extra: got 0x%0h expected none", dout_a);
      end else begin
        chk("word_a", {32'h0, dout_a}, {32'h0, exp_a.pop_front()});
      end
    end
    if (!rst && rd_b && !empty_b) begin
      if (exp_b.size() == 0) begin
        vecs++;
        bad++;
        $display("FAIL word_b_extra: got 0x%0h expected none", dout_b);
      end else begin
        chk("word_b", {32'h0, dout_b}, {32'h0, exp_b.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain_a(string nm);
    for (int n = 0; n < 60 && exp_a.size() > 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk(nm, exp_a.size(), 0);
    tick();
    rd_a = 1'b0;
  endtask

  task automatic drain_b(string nm);
    for (int n = 0; n < 60 && exp_b.size() > 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk(nm, exp_b.size(), 0);
    tick();
    rd_b = 1'b0;
  endtask

  task automatic push_a(int first, int num);
    for (int i = first; i < first + num; i++) begin
      up_a.push_back(i[7:0]);
    end
  endtask

  logic [31:0] d0;
  int nrd, last, fall;

  initial begin
    rd_a = 1'b0;
    rd_b = 1'b0;
    empty_i_a = 1'b1;
    empty_i_b = 1'b1;
    dout_i_a = 8'h00;
    dout_i_b = 8'h00;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_empty_a", empty_a, 1);
    chk("rst_rdi_a", rd_i_a, 0);
    chk("rst_empty_b", empty_b, 1);
    chk("rst_rdi_b", rd_i_b, 0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back streaming
    push_a(1, 8);
    exp_a.push_back(32'h04030201);
    exp_a.push_back(32'h08070605);
    pop_t_a.delete();
    drops = 0;
    watch = 1'b1;
    rd_a = 1'b1;
    drain_a("stream_left");
    watch = 1'b0;
    chk("stream_rdi_drops", drops, 0);
    chk("stream_pops", pop_t_a.size(), 2);
    if (pop_t_a.size() == 2) chk("stream_gap", pop_t_a[1] - pop_t_a[0], 4);

    // Downstream stall
    push_a(1, 6);
    exp_a.push_back(32'h04030201);
    for (int n = 0; n < 20 && empty_a; n++) begin
      @(negedge clk);
      #1;
    end
    chk("stall_ready", empty_a, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdi", rd_i_a, 0);
      chk("stall_dout", dout_a, 32'h04030201);
    end
    tick();
    rd_a = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_pulse_rdi", rd_i_a, 1);
    tick();
    rd_a = 1'b0;
    up_a.push_back(8'h07);
    up_a.push_back(8'h08);
    exp_a.push_back(32'h08070605);
    rd_a = 1'b1;
    drain_a("stall_left");

    // Sparse upstream
    viol = 0;
    sparse = 1'b1;
    push_a(8'h11, 8);
    exp_a.push_back(32'h14131211);
    exp_a.push_back(32'h18171615);
    rd_a = 1'b1;
    drain_a("sparse_left");
    sparse = 1'b0;
    chk("sparse_rdi_vs_empty_i", viol, 0);

    // Spurious read while empty
    tick();
    chk("spur_pre_empty", empty_a, 1);
    d0 = dout_a;
    rd_a = 1'b1;
    @(negedge clk);
    #1;
    chk("spur_rdi", rd_i_a, 0);
    tick();
    rd_a = 1'b0;
    @(negedge clk);
    chk("spur_empty", empty_a, 1);
    chk("spur_dout", dout_a, d0);
    push_a(8'h41, 4);
    exp_a.push_back(32'h44434241);
    rd_a = 1'b1;
    drain_a("spur_left");

    // Reset after two of four words are packed
    push_a(8'h21, 2);
    repeat (3) tick();
    chk("midrst_pre_empty", empty_a, 1);
    rst = 1'b1;
    up_a.delete();
    #1;
    chk("midrst_empty", empty_a, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    push_a(8'h31, 4);
    exp_a.push_back(32'h34333231);
    rd_a = 1'b1;
    drain_a("midrst_left");

    // Registered upstream: last read sampled at edge k, word captured at
    // edge k+1, so empty is first seen low two negedges after that read.
    for (int i = 0; i < 4; i++) begin
      up_b.push_back(8'hA0 + i[7:0]);
    end
    exp_b.push_back(32'hA3A2A1A0);
    nrd = 0;
    last = -100;
    fall = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (rd_i_b) begin
        nrd++;
        last = n;
      end
      if (!empty_b && fall < 0) fall = n;
    end
    chk("nla_rdi_count", nrd, 4);
    chk("nla_fall", fall, last + 2);
    chk("nla_dout", dout_b, 32'hA3A2A1A0);
    tick();
    rd_b = 1'b1;
    drain_b("nla_left");
    chk("rdi_vs_empty_i_all", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
